// File: rtl/trig_cap_pkg.sv
// Shared types and defaults for the triggered sample capture block.
package trig_cap_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned OVR_W          = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/trig_cap_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers.
module trig_cap_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Storage is not reset; gating on empty keeps the output at zero after reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trig_sample_capture.sv
// Captures din on trigger strobes while enabled, framing samples with tlast into a stream FIFO.
module trig_sample_capture
  import trig_cap_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [DATA_W-1:0] din,
  input  logic              enable,
  input  logic [15:0]       frame_len,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [15:0]       overrun_cnt,
  output logic              running
);

  cap_state_e       state_q;
  cap_state_e       state_n;
  logic             load;
  logic [15:0]      len_q;
  logic [15:0]      idx_q;
  logic [OVR_W-1:0] ovr_q;
  logic             sample;
  logic             push;
  logic             drop;
  logic             last;
  logic             full;
  logic             empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_n = RUN;
        load    = 1'b1;
      end
      RUN: if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sample = (state_q == RUN) && trigger;
  assign push   = sample && !full;
  assign drop   = sample && full;
  assign last   = (idx_q == len_q - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= 16'd1;
      idx_q <= '0;
      ovr_q <= '0;
    end else begin
      if (load) begin
        len_q <= (frame_len == 16'd0) ? 16'd1 : frame_len;
        idx_q <= '0;
      end else if (push) begin
        idx_q <= last ? '0 : idx_q + 16'd1;
      end
      if (drop && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
    end
  end

  trig_cap_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({din, last}),
    .pop   (m_tvalid && m_tready),
    .rdata ({m_tdata, m_tlast}),
    .full  (full),
    .empty (empty)
  );

  assign m_tvalid    = !empty;
  assign overrun_cnt = ovr_q;
  assign running     = (state_q == RUN);

endmodule
